// File: rtl/shift_request_scheduler.sv
// Round-robin scheduler that shares an external one-step arithmetic shifter between two
// requesters, iterating it to perform multi-step shifts with signed-overflow tracking.
module shift_request_scheduler #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] op0,
  input  logic             dir0,
  input  logic [CNT_W-1:0] cnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] op1,
  input  logic             dir1,
  input  logic [CNT_W-1:0] cnt1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             busy,
  output logic [WIDTH-1:0] sh_data,
  output logic             sh_dir,
  input  logic [WIDTH-1:0] sh_result
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] data;
  logic             dir;
  logic [CNT_W-1:0] counter;
  logic             owner;
  logic             last;
  logic             ovf_acc;

  // Requester 1 wins if it is the only one asking, or on a tie when 0 was served last.
  logic             pick1;
  logic [CNT_W-1:0] cnt_sel;

  always_comb begin
    pick1   = req1 & (~req0 | ~last);
    cnt_sel = pick1 ? cnt1 : cnt0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      data    <= '0;
      dir     <= 1'b0;
      counter <= '0;
      owner   <= 1'b0;
      last    <= 1'b1;
      ovf_acc <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req0 || req1) begin
            data    <= pick1 ? op1 : op0;
            dir     <= pick1 ? dir1 : dir0;
            counter <= cnt_sel;
            owner   <= pick1;
            last    <= pick1;
            ovf_acc <= 1'b0;
            gnt0    <= ~pick1;
            gnt1    <= pick1;
            state   <= (cnt_sel != '0) ? StShift : StDone;
          end
        end
        StShift: begin
          data    <= sh_result;
          counter <= counter - CNT_W'(1);
          // A left shift that changes the sign bit has lost signed magnitude.
          if (!dir && (sh_result[WIDTH-1] != data[WIDTH-1])) begin
            ovf_acc <= 1'b1;
          end
          if (counter == CNT_W'(1)) begin
            state <= StDone;
          end
        end
        StDone: begin
          result <= data;
          ovf    <= ovf_acc;
          done0  <= ~owner;
          done1  <= owner;
          state  <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign busy    = (state != StIdle);
  assign sh_data = data;
  assign sh_dir  = dir;

endmodule
